// File: rtl/swap_regfile.sv
// Multi-channel register-swap engine: NCH registers of WIDTH bits with LOAD,
// single-cycle direct swap and three-step XOR swap, one command at a time.
module swap_regfile #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int IDXW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [IDXW-1:0]      cmd_idx_a,
  input  logic [IDXW-1:0]      cmd_idx_b,
  input  logic [WIDTH-1:0]     cmd_data,
  output logic [NCH*WIDTH-1:0] regs_flat,
  output logic                 done,
  output logic                 err
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  typedef enum logic [1:0] {IDLE, X1, X2, X3} state_t;

  state_t           state_reg, state_next;
  logic [IDXW-1:0]  a_reg, a_next;
  logic [IDXW-1:0]  b_reg, b_next;
  logic             same_reg, same_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] regs_reg [NCH];

  logic             accept;
  logic             a_ok, b_ok;
  logic [IDXW-1:0]  sel_a, sel_b;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic             wr_a_en, wr_b_en;
  logic [WIDTH-1:0] wr_a_val, wr_b_val;

  assign cmd_ready = (state_reg == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign a_ok      = int'(cmd_idx_a) < NCH;
  assign b_ok      = int'(cmd_idx_b) < NCH;
  assign done      = done_reg;
  assign err       = err_reg;

  // In IDLE the live command indices address the file; during X1..X3 the captured ones do.
  assign sel_a = cmd_ready ? cmd_idx_a : a_reg;
  assign sel_b = cmd_ready ? cmd_idx_b : b_reg;

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_a == IDXW'(i)) rd_a = regs_reg[i];
      if (sel_b == IDXW'(i)) rd_b = regs_reg[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    same_next  = same_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    wr_a_en    = 1'b0;
    wr_b_en    = 1'b0;
    wr_a_val   = rd_a ^ rd_b;
    wr_b_val   = rd_a ^ rd_b;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD: begin
              if (a_ok) begin
                wr_a_en   = 1'b1;
                wr_a_val  = cmd_data;
                done_next = 1'b1;
              end else begin
                err_next = 1'b1;
              end
            end
            OP_SWAP: begin
              if (a_ok && b_ok) begin
                done_next = 1'b1;
                if (cmd_idx_a != cmd_idx_b) begin
                  wr_a_en  = 1'b1;
                  wr_b_en  = 1'b1;
                  wr_a_val = rd_b;
                  wr_b_val = rd_a;
                end
              end else begin
                err_next = 1'b1;
              end
            end
            OP_XOR: begin
              if (a_ok && b_ok) begin
                a_next     = cmd_idx_a;
                b_next     = cmd_idx_b;
                same_next  = (cmd_idx_a == cmd_idx_b);
                state_next = X1;
              end else begin
                err_next = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      // a == b still walks the three steps but writes nothing, so the value survives.
      X1: begin
        wr_a_en    = !same_reg;
        state_next = X2;
      end
      X2: begin
        wr_b_en    = !same_reg;
        state_next = X3;
      end
      X3: begin
        wr_a_en    = !same_reg;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      same_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      same_reg  <= same_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_a_en && sel_a == IDXW'(i))      regs_reg[i] <= wr_a_val;
        else if (wr_b_en && sel_b == IDXW'(i)) regs_reg[i] <= wr_b_val;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_flat
      assign regs_flat[gi*WIDTH +: WIDTH] = regs_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_swap_regfile.sv
// Bench for swap_regfile: directed scenarios plus random commands checked
// against an array model that applies each command as a whole exchange.
module tb_swap_regfile;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int NE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic            cmd_valid = 1'b0;
  logic [1:0]      cmd_op = 2'b00;
  logic [IW-1:0]   cmd_idx_a = '0;
  logic [IW-1:0]   cmd_idx_b = '0;
  logic [W-1:0]    cmd_data = '0;
  logic            cmd_ready, done, err;
  logic [N*W-1:0]  regs_flat;

  logic            e_valid = 1'b0;
  logic [1:0]      e_op = 2'b00;
  logic [IW-1:0]   e_idx_a = '0;
  logic [IW-1:0]   e_idx_b = '0;
  logic [W-1:0]    e_data = '0;
  logic            e_ready, e_done, e_err;
  logic [NE*W-1:0] e_regs;

  int total = 0;
  int bad = 0;
  logic [W-1:0] mdl [N];

  always #5 clk = ~clk;

  swap_regfile #(.WIDTH(W), .NCH(N), .IDXW(IW)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx_a(cmd_idx_a), .cmd_idx_b(cmd_idx_b),
    .cmd_data(cmd_data), .regs_flat(regs_flat), .done(done), .err(err)
  );

  swap_regfile #(.WIDTH(W), .NCH(NE), .IDXW(IW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(e_valid), .cmd_ready(e_ready),
    .cmd_op(e_op), .cmd_idx_a(e_idx_a), .cmd_idx_b(e_idx_b),
    .cmd_data(e_data), .regs_flat(e_regs), .done(e_done), .err(e_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] pack_mdl();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = mdl[i];
    return r;
  endfunction

  // Issue one command on the main instance, wait for its completion and compare.
  task automatic send(input logic [1:0] op, input int a, input int b, input logic [W-1:0] d);
    int n;
    int lat;
    int exp_lat;
    logic [W-1:0] t;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx_a = a[IW-1:0];
    cmd_idx_b = b[IW-1:0];
    cmd_data  = d;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("ready_wait", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_idx_a = IW'($urandom);
    cmd_idx_b = IW'($urandom);
    cmd_data  = W'($urandom);
    case (op)
      2'b01: mdl[a] = d;
      2'b10, 2'b11: begin
        t      = mdl[a];
        mdl[a] = mdl[b];
        mdl[b] = t;
      end
      default: ;
    endcase
    if (op == 2'b00) begin
      chk("nop_pulse", 64'({done, err}), 64'(0));
      chk("nop_regs", 64'(regs_flat), 64'(pack_mdl()));
      $display("op=%0d a=%0d b=%0d d=%02h regs=%08h", op, a, b, d, regs_flat);
      return;
    end
    exp_lat = (op == 2'b11) ? 3 : 0;
    lat = 0;
    while (!(done || err) && lat < 8) begin
      chk("busy_ready", 64'(cmd_ready), 64'(0));
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("done", 64'(done), 64'(1));
    chk("err", 64'(err), 64'(0));
    chk("regs", 64'(regs_flat), 64'(pack_mdl()));
    chk("ready_after", 64'(cmd_ready), 64'(1));
    $display("op=%0d a=%0d b=%0d d=%02h lat=%0d regs=%08h", op, a, b, d, lat, regs_flat);
  endtask

  task automatic esend(input logic [1:0] op, input int a, input int b, input logic [W-1:0] d,
                       input logic exp_e, input logic [NE*W-1:0] exp_regs);
    e_valid = 1'b1;
    e_op    = op;
    e_idx_a = a[IW-1:0];
    e_idx_b = b[IW-1:0];
    e_data  = d;
    tick();
    e_valid = 1'b0;
    chk("e_err", 64'(e_err), 64'(exp_e));
    chk("e_done", 64'(e_done), 64'(!exp_e));
    chk("e_regs", 64'(e_regs), 64'(exp_regs));
    chk("e_ready", 64'(e_ready), 64'(1));
    $display("nch3 op=%0d a=%0d b=%0d err=%0d regs=%06h", op, a, b, e_err, e_regs);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) mdl[i] = '0;

    // reset values while held low, then after release
    #3;
    chk("rst_regs", 64'(regs_flat), 64'(0));
    chk("rst_ready", 64'(cmd_ready), 64'(1));
    chk("rst_pulse", 64'({done, err}), 64'(0));
    chk("rst_e_ready", 64'(e_ready), 64'(1));
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rel_regs", 64'(regs_flat), 64'(0));
    chk("rel_ready", 64'(cmd_ready), 64'(1));
    chk("rel_pulse", 64'({done, err}), 64'(0));

    // back-to-back LOAD, LOAD, SWAP_DIRECT
    send(2'b01, 0, 0, 8'h3C);
    send(2'b01, 1, 0, 8'hA5);
    send(2'b10, 0, 1, 8'h00);
    chk("bb_r0", 64'(regs_flat[7:0]), 64'(8'hA5));
    chk("bb_r1", 64'(regs_flat[15:8]), 64'(8'h3C));

    // XOR swap with intermediate values and a held command behind it
    send(2'b01, 2, 0, 8'h0F);
    send(2'b01, 3, 0, 8'hF0);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_idx_a = 2'd2; cmd_idx_b = 2'd3;
    tick();
    cmd_op = 2'b01; cmd_idx_a = 2'd0; cmd_data = 8'h77;
    chk("x0_ready", 64'(cmd_ready), 64'(0));
    chk("x0_done", 64'(done), 64'(0));
    tick();
    chk("x1_r2", 64'(regs_flat[23:16]), 64'(8'hFF));
    chk("x1_ready", 64'(cmd_ready), 64'(0));
    tick();
    chk("x2_r3", 64'(regs_flat[31:24]), 64'(8'h0F));
    chk("x2_ready", 64'(cmd_ready), 64'(0));
    tick();
    chk("x3_r2", 64'(regs_flat[23:16]), 64'(8'hF0));
    chk("x3_done", 64'(done), 64'(1));
    chk("x3_ready", 64'(cmd_ready), 64'(1));
    chk("x3_held_r0", 64'(regs_flat[7:0]), 64'(8'hA5));
    tick();
    cmd_valid = 1'b0;
    chk("held_load", 64'(regs_flat[7:0]), 64'(8'h77));
    chk("held_done", 64'(done), 64'(1));
    mdl[0] = 8'h77; mdl[2] = 8'hF0; mdl[3] = 8'h0F;
    $display("xor(2,3) regs=%08h", regs_flat);

    // same-index swaps keep the value
    send(2'b01, 1, 0, 8'h5A);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_idx_a = 2'd1; cmd_idx_b = 2'd1;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("xs_r1", 64'(regs_flat[15:8]), 64'(8'h5A));
      chk("xs_done", 64'(done), 64'(0));
      tick();
    end
    chk("xs_r1_end", 64'(regs_flat[15:8]), 64'(8'h5A));
    chk("xs_done_end", 64'(done), 64'(1));
    $display("xor(1,1) regs=%08h", regs_flat);
    send(2'b10, 1, 1, 8'h00);
    chk("ds_r1", 64'(regs_flat[15:8]), 64'(8'h5A));

    // out-of-range indices on a three-register instance
    esend(2'b01, 0, 0, 8'h42, 1'b0, 24'h000042);
    esend(2'b01, 3, 0, 8'h99, 1'b1, 24'h000042);
    esend(2'b10, 0, 3, 8'h00, 1'b1, 24'h000042);
    esend(2'b11, 3, 1, 8'h00, 1'b1, 24'h000042);
    tick();
    chk("e_err_once", 64'(e_err), 64'(0));
    chk("e_idle_ready", 64'(e_ready), 64'(1));
    esend(2'b10, 0, 2, 8'h00, 1'b0, 24'h420000);

    // reset in the middle of an XOR swap
    send(2'b01, 0, 0, 8'h11);
    send(2'b01, 1, 0, 8'h22);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_idx_a = 2'd0; cmd_idx_b = 2'd1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rx_r0", 64'(regs_flat[7:0]), 64'(8'h33));
    #2 rst_n = 1'b0;
    #1;
    chk("rx_regs", 64'(regs_flat), 64'(0));
    chk("rx_ready", 64'(cmd_ready), 64'(1));
    chk("rx_pulse", 64'({done, err}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rx_rel_regs", 64'(regs_flat), 64'(0));
    chk("rx_rel_done", 64'(done), 64'(0));
    tick();
    chk("rx_rel_done2", 64'(done), 64'(0));
    chk("rx_rel_ready", 64'(cmd_ready), 64'(1));
    for (int i = 0; i < N; i++) mdl[i] = '0;
    send(2'b01, 2, 0, 8'h6E);

    // random commands against the model
    for (int it = 0; it < 200; it++) begin
      send(2'($urandom_range(0, 3)), int'($urandom_range(0, N-1)),
           int'($urandom_range(0, N-1)), W'($urandom));
      if ($urandom_range(0, 7) == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
